// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock circular-buffer FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow and a
// selectable registered (FWFT=0) or first-word-fall-through (FWFT=1) read port.
module param_sync_fifo #(
  parameter int DW     = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  parameter bit FWFT   = 1'b0,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic [DW-1:0] din_i,
  input  logic          wr_en_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] dout_o,
  output logic          dout_vld_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic [CW-1:0] count_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be at least 2");
  end
  if (AF_LVL > DEPTH || AF_LVL < 1) begin : g_bad_af
    $error("param_sync_fifo: AF_LVL must lie in 1..DEPTH");
  end
  if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
    $error("param_sync_fifo: AE_LVL must lie in 0..DEPTH-1");
  end

  logic [DW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc, mem_we;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  // Accept decisions, pointer/count next state and flags derived from next count.
  always_comb begin
    wr_acc   = wr_en_i & ~full_q;
    rd_acc   = rd_en_i & ~empty_q;
    mem_we   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      mem_we = wr_acc;
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wr_en_i && full_q)  ovf_d = 1'b1;
      if (rd_en_i && empty_q) udf_d = 1'b1;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= din_i;
  end

  if (FWFT) begin : g_fwft
    // Head word is presented combinationally whenever the FIFO holds data.
    always_comb begin
      dout_o     = mem[rd_ptr_q];
      dout_vld_o = ~empty_q;
    end
  end else begin : g_reg
    logic [DW-1:0] dout_q;
    logic          dout_vld_q;

    // Registered read: capture head on accepted pop, valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q     <= '0;
        dout_vld_q <= 1'b0;
      end else if (clr_i) begin
        dout_vld_q <= 1'b0;
      end else begin
        dout_vld_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr_q];
      end
    end

    // Drive read port from the registered data.
    always_comb begin
      dout_o     = dout_q;
      dout_vld_o = dout_vld_q;
    end
  end

  // Status outputs straight from registers.
  always_comb begin
    count_o        = count_q;
    full_o         = full_q;
    empty_o        = empty_q;
    almost_full_o  = af_q;
    almost_empty_o = ae_q;
    overflow_o     = ovf_q;
    underflow_o    = udf_q;
  end

endmodule
